// File: rtl/serializer.sv
// serializer: parallel word to MSB-first serial stream.
// One active shift word plus a one-word holding buffer for gapless output.
module serializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] ONE      = (MOD_W+1)'(1);

  state_t            state_q, state_d;
  logic [MOD_W:0]    cnt_q, cnt_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [MOD_W:0]    hold_len_q;
  logic              bit_d, val_d;

  logic [MOD_W:0]    req_len;
  logic              req_ok, accept;
  logic              load_req, load_hold;
  logic              shift_en, store_hold;

  always_comb begin
    req_len = (data_mod_i == '0) ? FULL_LEN
                                 : {1'b0, data_mod_i};
    req_ok  = (data_mod_i != MOD_W'(1)) &&
              (data_mod_i != MOD_W'(2));
    accept  = data_val_i & ~hold_full_q & req_ok;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    bit_d       = 1'b0;
    val_d       = 1'b0;
    load_req    = 1'b0;
    load_hold   = 1'b0;
    shift_en    = 1'b0;
    store_hold  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load_req = 1'b1;
          state_d  = SHIFT;
          cnt_d    = req_len;
          val_d    = 1'b1;
          bit_d    = data_i[DATA_W-1];
        end
      end
      SHIFT: begin
        // cnt_q counts bits left, including the one now on the wire
        if (cnt_q > ONE) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - ONE;
          val_d    = 1'b1;
          bit_d    = shift_q[DATA_W-1];
          if (accept) begin
            store_hold  = 1'b1;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          load_hold   = 1'b1;
          hold_full_d = 1'b0;
          cnt_d       = hold_len_q;
          val_d       = 1'b1;
          bit_d       = hold_data_q[DATA_W-1];
        end else if (accept) begin
          load_req = 1'b1;
          cnt_d    = req_len;
          val_d    = 1'b1;
          bit_d    = data_i[DATA_W-1];
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      hold_full_q    <= 1'b0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hold_full_q    <= hold_full_d;
      ser_data_o     <= bit_d;
      ser_data_val_o <= val_d;
    end
  end

  // Datapath only; validity is tracked by the reset flops above
  always_ff @(posedge clk_i) begin
    if (load_req)
      shift_q <= data_i << 1;
    else if (load_hold)
      shift_q <= hold_data_q << 1;
    else if (shift_en)
      shift_q <= shift_q << 1;
    if (store_hold) begin
      hold_data_q <= data_i;
      hold_len_q  <= req_len;
    end
  end

  assign busy_o = hold_full_q;

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial converter feeding the `deserializer` stage. It accepts a parallel word plus a valid-bit count and shifts the valid bits out MSB-first, one per clock. Its `ser_data_o`/`ser_data_val_o` pair connects directly to the deserializer's `data_i`/`data_val_i`. A one-word holding buffer lets back-to-back words leave as a gapless bit stream.

## Interface
- `DATA_W`, 16: parallel word width; power of two, ≥ 4.
- `MOD_W`, $clog2(DATA_W): width of the bit-count input.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `arstn_i`  in  1  asynchronous, active-low reset.
- `data_i`  in  DATA_W  parallel word; bit DATA_W-1 is sent first.
- `data_mod_i`  in  MOD_W  number of valid bits; 0 means DATA_W.
- `data_val_i`  in  1  word request, sampled every cycle.
- `ser_data_o`  out  1  serial bit.
- `ser_data_val_o`  out  1  high while `ser_data_o` carries a valid bit.
- `busy_o`  out  1  high while the holding buffer is full; requests are dropped while it is high.

## Operation
- **Bit count.** len = DATA_W when `data_mod_i`==0, otherwise len = `data_mod_i`.
- **Bits sent.** The block sends `data_i[DATA_W-1]` down to `data_i[DATA_W-len]`.
- **Illegal counts.** `data_mod_i` of 1 or 2 is illegal. Such a request is silently discarded and does not change any state.
- **Accept rule.** A request is accepted when `data_val_i`=1, `busy_o`=0 and the count is legal.
- **Storage.** Shift register (DATA_W bits) and remaining-bit counter (MOD_W+1 bits) for the active word. Holding register (data + len) with a `hold_full` flag.
- **FSM states:**
  - IDLE: nothing shifting.
    - Accepted word loads the shift register; go to SHIFT.
  - SHIFT: each cycle one bit is sent and the counter decrements.
    - Accepted word while the counter is > 1 goes to the holding register; `hold_full` is set.
    - On the last-bit cycle (counter==1):
      - if `hold_full`: load the shift register from hold, clear `hold_full`, stay in SHIFT;
      - else if a word is accepted this cycle: bypass it straight into the shift register, stay in SHIFT;
      - else: go to IDLE.
- **Buffer depth.** At most two words are in flight: one shifting, one held.
- **Flow control.** `busy_o` = `hold_full`. It is a registered flag, so it is valid from the start of the cycle. It clears in the same cycle the held word moves into the shift register, and a new word is accepted that cycle only if it is the last-bit cycle (bypass).
- **Idle outputs.** `ser_data_o` is 0 whenever `ser_data_val_o` is 0.
- **Reset.** Asserting `arstn_i` at any time, mid-word included, clears immediately:
  - FSM → IDLE;
  - `hold_full` → 0;
  - counter → 0;
  - all outputs → 0.
  
  A partial word is lost, not resumed. The shift register and holding data need no reset.

## Timing
- Reset values: `ser_data_o`=0, `ser_data_val_o`=0, `busy_o`=0.
- All outputs are registered.
- Word accepted in cycle N from IDLE: first bit in N+1, last bit in N+len. `ser_data_val_o` is high for exactly len consecutive cycles.
- Back-to-back: the next word's first bit follows the previous word's last bit in the very next cycle, with no idle cycle. This holds whether the next word came from hold or from bypass.
- `busy_o` rises the cycle after a word is accepted into hold. It falls the cycle after the held word is loaded.
- After reset deasserts, the first request is accepted on the first rising clock edge.

## Test plan
- **Single full word.** Reset, then `data_i`=16'hA5C3, mod=0, 1-cycle valid. Expect 16 bits 1010_0101_1100_0011, then `ser_data_val_o` drops and the FSM returns to IDLE.
- **Short word.** `data_i`=16'hE000, mod=3. Expect bits 1,1,1 over 3 valid cycles. Separately, mod=1 and mod=2 produce no output and `busy_o` stays 0.
- **Gapless stream.** Hold `data_val_i`=1 with words 16'h0001, 16'h8000, 16'hFFFF (mod=0), each advanced only when accepted. Expect 48 contiguous valid bits and `busy_o` pattern per the flow-control rule. Looped into the `deserializer`, it must output 16'h0001, 16'h8000, 16'hFFFF.
- **Overflow drop.** While shifting and hold is full, present 16'h1234. Expect it not to be sent and `busy_o`=1 during that cycle.
- **Bypass.** Present a word exactly on the last-bit cycle with hold empty. Expect its first bit in the next cycle, no gap, and `busy_o` still 0.
- **Async reset mid-word.** Pulse `arstn_i` low between clock edges after 5 bits of 16'hFFFF. Expect outputs at 0 immediately, no remaining bits, and the next word sent correctly from its MSB.
